// File: rtl/pwr_pkg.sv
// Shared types and default timing constants for the supply power-good return path.
// Also used by conf_power_supply so both sides agree on debounce and ramp limits.
package pwr_pkg;

    typedef enum logic [1:0] {
        PWR_OFF   = 2'd0,
        PWR_RAMP  = 2'd1,
        PWR_ON    = 2'd2,
        PWR_FAULT = 2'd3
    } pwr_state_t;

    localparam int PWR_DEBOUNCE_CYC_DEF = 16;
    localparam int PWR_TIMEOUT_CYC_DEF  = 100000;

endpackage

// File: rtl/pwr_pg_debounce.sv
// Two-flop synchroniser plus stability filter for one asynchronous power-good line.
// The filtered value only follows the synchronised input after DEBOUNCE_CYC steady cycles.
module pwr_pg_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pg_i,
    output logic filt_o
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter measures how long s2 has disagreed with the filtered value.
    always_comb begin
        s1_d   = pg_i;
        s2_d   = s1_q;
        filt_d = filt_q;
        cnt_d  = '0;
        if (s2_q != filt_q) begin
            if (cnt_q == CNT_MAX) begin
                filt_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/pwr_good_monitor.sv
// Power-good monitor: conditions each rail's PG feedback and sequences OFF/RAMP/ON/FAULT
// against the enable we drive, latching which rails were bad when a fault is declared.
module pwr_good_monitor
    import pwr_pkg::*;
#(
    parameter int N_RAILS      = 2,
    parameter int DEBOUNCE_CYC = PWR_DEBOUNCE_CYC_DEF,
    parameter int TIMEOUT_CYC  = PWR_TIMEOUT_CYC_DEF,
    parameter int TMR_W        = $clog2(TIMEOUT_CYC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwr_en_i,
    input  logic [N_RAILS-1:0] pg_i,
    input  logic               clr_fault_i,
    output logic               pwr_ok_o,
    output logic               fault_o,
    output logic [N_RAILS-1:0] fault_rail_o,
    output logic [N_RAILS-1:0] pg_filt_o,
    output logic [1:0]         state_o
);

    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC - 1);

    logic [N_RAILS-1:0] pg_filt;
    logic               all_good;

    pwr_state_t         state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N_RAILS-1:0] fault_rail_q, fault_rail_d;

    for (genvar r = 0; r < N_RAILS; r++) begin : g_rail
        pwr_pg_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .pg_i  (pg_i[r]),
            .filt_o(pg_filt[r])
        );
    end

    assign all_good = &pg_filt;

    // Disable always wins so an expected PG collapse on shutdown is never a fault;
    // in RAMP a rail arriving on the timeout cycle still counts as a good power-up.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        fault_rail_d = fault_rail_q;
        case (state_q)
            PWR_OFF: begin
                if (pwr_en_i) begin
                    state_d = PWR_RAMP;
                    timer_d = '0;
                end
            end
            PWR_RAMP: begin
                if (!pwr_en_i) begin
                    state_d = PWR_OFF;
                end else if (all_good) begin
                    state_d = PWR_ON;
                end else if (timer_q == TMR_MAX) begin
                    state_d      = PWR_FAULT;
                    fault_rail_d = ~pg_filt;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            PWR_ON: begin
                if (!pwr_en_i) begin
                    state_d = PWR_OFF;
                end else if (!all_good) begin
                    state_d      = PWR_FAULT;
                    fault_rail_d = ~pg_filt;
                end
            end
            PWR_FAULT: begin
                if (clr_fault_i && !pwr_en_i) begin
                    state_d      = PWR_OFF;
                    fault_rail_d = '0;
                end
            end
            default: state_d = PWR_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PWR_OFF;
            timer_q      <= '0;
            fault_rail_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            fault_rail_q <= fault_rail_d;
        end
    end

    assign pwr_ok_o     = (state_q == PWR_ON);
    assign fault_o      = (state_q == PWR_FAULT);
    assign fault_rail_o = fault_rail_q;
    assign pg_filt_o    = pg_filt;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pwr_good_monitor.sv
// Directed bench for pwr_good_monitor with a behavioural reference model checked every cycle
// and hand-computed literal expectations at key points of each scenario.
module tb_pwr_good_monitor;

    localparam int N = 2;
    localparam int D = 4;
    localparam int T = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         pwr_en;
    logic [N-1:0] pg;
    logic         clr_fault;
    logic         pwr_ok;
    logic         fault;
    logic [N-1:0] fault_rail;
    logic [N-1:0] pg_filt;
    logic [1:0]   state;

    int n_checks = 0;
    int n_pass   = 0;

    pwr_good_monitor #(
        .N_RAILS     (N),
        .DEBOUNCE_CYC(D),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwr_en_i    (pwr_en),
        .pg_i        (pg),
        .clr_fault_i (clr_fault),
        .pwr_ok_o    (pwr_ok),
        .fault_o     (fault),
        .fault_rail_o(fault_rail),
        .pg_filt_o   (pg_filt),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    // Reference model: a rail's filtered PG takes the value that the input held, two
    // samples delayed, for the last D cycles whenever that value differs from it.
    int           m_state;
    int           m_age;
    int           m_next;
    logic [N-1:0] m_rail;
    logic [N-1:0] m_filt;
    logic [N-1:0] m_filt_next;
    logic [N-1:0] hist [0:D];
    logic         m_stable;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0;
            m_age   = 0;
            m_rail  = '0;
            m_filt  = '0;
            for (int j = 0; j <= D; j++) hist[j] = '0;
        end else begin
            m_next = m_state;
            case (m_state)
                0: if (pwr_en) begin m_next = 1; m_age = 0; end
                1: begin
                    if (!pwr_en) m_next = 0;
                    else if (&m_filt) m_next = 2;
                    else if (m_age == T - 1) begin m_next = 3; m_rail = ~m_filt; end
                    else m_age = m_age + 1;
                end
                2: begin
                    if (!pwr_en) m_next = 0;
                    else if (!(&m_filt)) begin m_next = 3; m_rail = ~m_filt; end
                end
                default: if (clr_fault && !pwr_en) begin m_next = 0; m_rail = '0; end
            endcase
            m_state = m_next;
            m_filt_next = m_filt;
            for (int r = 0; r < N; r++) begin
                m_stable = 1'b1;
                for (int j = 1; j <= D; j++)
                    if (hist[j][r] != hist[1][r]) m_stable = 1'b0;
                if (m_stable && hist[1][r] != m_filt[r]) m_filt_next[r] = hist[1][r];
            end
            m_filt = m_filt_next;
            for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = pg;
        end
    end

    // Every-cycle comparison of all outputs against the model while out of reset.
    logic [2*N+3:0] dut_vec, mdl_vec;
    always @(negedge clk) begin
        if (!rst) begin
            dut_vec = {state, pwr_ok, fault, fault_rail, pg_filt};
            mdl_vec = {m_state[1:0], (m_state == 2), (m_state == 3), m_rail, m_filt};
            n_checks++;
            if (dut_vec === mdl_vec) n_pass++;
            else $display("[TB] FAIL model_cycle t=%0t got {st,ok,flt,rail,filt}=%b want %b",
                          $time, dut_vec, mdl_vec);
        end
    end

    task automatic applyStimulus(input logic en, input logic [N-1:0] p, input logic clr,
                                 input int ticks);
        pwr_en    = en;
        pg        = p;
        clr_fault = clr;
        repeat (ticks) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [1:0] e_state, input logic e_ok,
                               input logic e_fault, input logic [N-1:0] e_rail,
                               input logic [N-1:0] e_filt);
        logic [2*N+3:0] got, exp, mdl;
        got = {state, pwr_ok, fault, fault_rail, pg_filt};
        exp = {e_state, e_ok, e_fault, e_rail, e_filt};
        mdl = {m_state[1:0], (m_state == 2), (m_state == 3), m_rail, m_filt};
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s got {st,ok,flt,rail,filt}=%b want %b", name, got, exp);
        n_checks++;
        if (mdl === exp) n_pass++;
        else $display("[TB] FAIL %s/model got %b want %b", name, mdl, exp);
    endtask

    initial begin
        rst       = 1'b1;
        pwr_en    = 1'b0;
        pg        = '0;
        clr_fault = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset", 2'd0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Normal power-up: filtered PG after 6 edges, ON one edge later.
        applyStimulus(1'b1, 2'b11, 1'b0, 6);
        checkOutput("pu_ramp", 2'd1, 1'b0, 1'b0, 2'b00, 2'b11);
        applyStimulus(1'b1, 2'b11, 1'b0, 1);
        checkOutput("pu_on", 2'd2, 1'b1, 1'b0, 2'b00, 2'b11);

        // Glitch rejection then a long enough dropout on rail 1.
        applyStimulus(1'b1, 2'b01, 1'b0, 3);
        applyStimulus(1'b1, 2'b11, 1'b0, 10);
        checkOutput("glitch3", 2'd2, 1'b1, 1'b0, 2'b00, 2'b11);
        applyStimulus(1'b1, 2'b01, 1'b0, 5);
        applyStimulus(1'b1, 2'b11, 1'b0, 2);
        checkOutput("glitch5", 2'd3, 1'b0, 1'b1, 2'b10, 2'b01);

        // Clear rules.
        applyStimulus(1'b1, 2'b11, 1'b1, 1);
        applyStimulus(1'b1, 2'b11, 1'b0, 8);
        checkOutput("clr_en1", 2'd3, 1'b0, 1'b1, 2'b10, 2'b11);
        applyStimulus(1'b0, 2'b11, 1'b0, 3);
        checkOutput("fault_en0", 2'd3, 1'b0, 1'b1, 2'b10, 2'b11);
        applyStimulus(1'b0, 2'b11, 1'b1, 1);
        checkOutput("clr_exit", 2'd0, 1'b0, 1'b0, 2'b00, 2'b11);
        applyStimulus(1'b0, 2'b11, 1'b0, 1);

        // Orderly shutdown from ON with PG dropping together with enable.
        applyStimulus(1'b1, 2'b11, 1'b0, 2);
        checkOutput("re_on", 2'd2, 1'b1, 1'b0, 2'b00, 2'b11);
        applyStimulus(1'b0, 2'b00, 1'b0, 1);
        checkOutput("shutdown", 2'd0, 1'b0, 1'b0, 2'b00, 2'b11);
        applyStimulus(1'b0, 2'b00, 1'b0, 8);
        checkOutput("off_idle", 2'd0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Ramp timeout with rail 1 never good.
        applyStimulus(1'b0, 2'b01, 1'b0, 8);
        applyStimulus(1'b1, 2'b01, 1'b0, 20);
        checkOutput("to_ramp", 2'd1, 1'b0, 1'b0, 2'b00, 2'b01);
        applyStimulus(1'b1, 2'b01, 1'b0, 1);
        checkOutput("to_fault", 2'd3, 1'b0, 1'b1, 2'b10, 2'b01);
        applyStimulus(1'b0, 2'b01, 1'b1, 1);
        checkOutput("to_clr", 2'd0, 1'b0, 1'b0, 2'b00, 2'b01);
        applyStimulus(1'b0, 2'b01, 1'b0, 1);

        // All-good arrives on the final timer cycle: ON wins.
        applyStimulus(1'b1, 2'b01, 1'b0, 14);
        applyStimulus(1'b1, 2'b11, 1'b0, 6);
        checkOutput("race_ramp", 2'd1, 1'b0, 1'b0, 2'b00, 2'b11);
        applyStimulus(1'b1, 2'b11, 1'b0, 1);
        checkOutput("race_on", 2'd2, 1'b1, 1'b0, 2'b00, 2'b11);

        // One cycle too late: timeout fires with the old filtered value latched.
        applyStimulus(1'b0, 2'b01, 1'b0, 8);
        checkOutput("race_off", 2'd0, 1'b0, 1'b0, 2'b00, 2'b01);
        applyStimulus(1'b1, 2'b01, 1'b0, 15);
        applyStimulus(1'b1, 2'b11, 1'b0, 6);
        checkOutput("late_fault", 2'd3, 1'b0, 1'b1, 2'b10, 2'b11);
        applyStimulus(1'b0, 2'b11, 1'b1, 1);
        applyStimulus(1'b0, 2'b11, 1'b0, 1);

        // Asynchronous reset from ON, observed between clock edges.
        applyStimulus(1'b1, 2'b11, 1'b0, 2);
        checkOutput("pre_rst_on", 2'd2, 1'b1, 1'b0, 2'b00, 2'b11);
        #2 rst = 1'b1;
        #1 checkOutput("async_rst", 2'd0, 1'b0, 1'b0, 2'b00, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 4);
        checkOutput("post_rst", 2'd0, 1'b0, 1'b0, 2'b00, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
